rpn_stack_core: RTL and testbench
=================================

// Module: rpn_stack_core
// PURPOSE
//  Parametrised RPN evaluation core: operand stack plus unsigned ALU behind a valid/ready command port.
//  Adds DUP/SWAP/MUL, an iterative divide, selectable wrap/saturate arithmetic and explicit error reporting.
//  Sits between the KEY/SW front-end (debounce, command encode) and the LEDR/HEX display logic of the calculator top level.
// PARAMETERS
//  DATA_W    8  operand/result width, unsigned, >=2
//  DEPTH     8  stack entries, >=2, need not be a power of two
//  SATURATE  0  0: results wrap modulo 2^DATA_W; 1: results clamp to [0, 2^DATA_W-1]
// PORTS
//  CLOCK_50   in   1                     single clock, rising edge
//  reset      in   1                     asynchronous, active-high; clears stack, aborts any op
//  cmd_valid  in   1                     command offered
//  cmd_ready  out  1                     core can accept a command this cycle
//  cmd_op     in   3                     opcode (rpn_pkg encoding)
//  cmd_data   in   DATA_W                operand for PUSH, ignored otherwise
//  rsp_valid  out  1                     one-cycle pulse: accepted command completed
//  rsp_err    out  4                     valid with rsp_valid: {arith_ovf, div0, stack_ovf, stack_unf}
//  top        out  DATA_W                top-of-stack, 0 when empty
//  depth      out  $clog2(DEPTH+1)       current entry count 0..DEPTH
// BEHAVIOUR
//  Reset: stack cleared, depth=0, top=0, rsp_valid=0, rsp_err=0, cmd_ready=1, FSM=IDLE.
//  Accept when cmd_valid & cmd_ready on a rising edge. B = top, A = entry below top.
//  Ops: 0 PUSH d; 1 DROP; 2 ADD A+B; 3 SUB A-B; 4 MUL A*B; 5 DIV A/B (quotient); 6 SWAP; 7 DUP.
//   Binary ops pop A,B and push result (depth-1). SWAP exchanges A,B. DUP pushes a copy of B.
//  Preconditions -> error, stack/depth untouched, rsp_valid still pulses:
//   DROP needs depth>=1; DUP needs 1<=depth<DEPTH; binary ops/SWAP need depth>=2 -> stack_unf.
//   PUSH or DUP at depth==DEPTH -> stack_ovf. DIV with B==0 -> div0.
//  Arithmetic: full-precision result computed, then reduced to DATA_W:
//   ADD/MUL true result > max: arith_ovf=1; SATURATE=0 keeps low DATA_W bits, =1 gives all-ones.
//   SUB with A<B: arith_ovf=1; SATURATE=0 gives two's-complement wrap, =1 gives 0.
//   arith_ovf is a warning: the result is still written.
//  FSM: IDLE, DIV_RUN.
//   IDLE: cmd_ready=1. Non-DIV command (or any errored command) accepted in cycle t
//   -> stack updated at end of t, rsp_valid=1 in t+1, back-to-back commands allowed.
//   Valid DIV accepted in t -> DIV_RUN, cmd_ready=0 for cycles t+1..t+DATA_W.
//   Divider does one restoring step per cycle.
//   Result written at end of t+DATA_W; rsp_valid=1 and cmd_ready=1 in t+DATA_W+1.
//   DIV_RUN ignores cmd_valid.
//  rsp_err is zero whenever rsp_valid=0. top/depth are registered and reflect the state after the last completed op.
//  Reset at any time, including mid-DIV_RUN: immediate clear, no rsp_valid for the aborted op.
// STRUCTURE
//  rpn_pkg: OP_* opcode localparams, ERR_* bit indices of rsp_err, FSM state encoding.
//  Sub-module rpn_divider (DATA_W param; start, a, b -> busy, done, q), iterative restoring divider, async reset.
//  Stack is a DEPTH x DATA_W register array plus pointer. The ALU is combinational in the core.
// TESTING  (DATA_W=8, DEPTH=4 unless noted)
//  1 PUSH 0xAE, PUSH 0x83, ADD -> SAT=0: top=0x31, depth=1, rsp_err=4'b1000; SAT=1: top=0xFF.
//  2 PUSH 1,2,3,4,5 -> 5th: rsp_err=4'b0010, depth=4, top=0x04; then SWAP -> top=0x03; DUP -> stack_ovf.
//  3 From reset: ADD -> rsp_err=4'b0001, depth=0. DROP -> stack_unf. PUSH 9, SWAP -> stack_unf, top=0x09.
//  4 PUSH 0xC8, PUSH 0x07, DIV -> cmd_ready low exactly 8 cycles, rsp_valid 9 cycles after accept, top=0x1C, depth=1.
//    PUSH 0, DIV -> rsp_err=4'b0100 next cycle, depth=2, top=0x00.
//  5 PUSH 3, PUSH 5, SUB -> SAT=0: top=0xFE, arith_ovf; SAT=1: top=0x00. PUSH 0x10, DUP, MUL -> SAT=0: 0x00 + arith_ovf.
//  6 Start DIV 0xC8/0x07, assert reset 4 cycles in -> depth=0, top=0, cmd_ready=1, no rsp_valid ever for that DIV.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator core: opcodes, response error bit
// positions and the core FSM state encoding.
package rpn_pkg;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_DROP = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_DUP  = 3'd7;

    localparam int ERR_UNF  = 0;
    localparam int ERR_SOVF = 1;
    localparam int ERR_DIV0 = 2;
    localparam int ERR_AOVF = 3;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_DIV_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/rpn_divider.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
// done and q are valid combinationally during the final step so the caller can commit that cycle.
module rpn_divider #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] q
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [CW-1:0]     step;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    // One restoring step; a set borrow bit in trial means the subtraction is undone.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[DATA_W]) begin
            rem_next = shifted[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b0};
        end else begin
            rem_next = trial[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

    assign done = busy && (step == LAST);
    assign q    = quo_next;

    // Operand capture on start, then one step per cycle until the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            step <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            rem  <= '0;
            quo  <= a;
            dvs  <= b;
            step <= '0;
        end else if (busy) begin
            rem  <= rem_next;
            quo  <= quo_next;
            step <= step + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rpn_stack_core.sv
// RPN evaluation core: register-array operand stack, combinational unsigned ALU,
// and a two-state FSM that stalls the command port while the iterative divider runs.
module rpn_stack_core
    import rpn_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         rsp_valid,
    output logic [3:0]                   rsp_err,
    output logic [DATA_W-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

    state_t             state;
    logic [DATA_W-1:0]  stack [DEPTH];
    logic [CNT_W-1:0]   idx_a;
    logic [CNT_W-1:0]   idx_b;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]  alu_res;
    logic               aovf;
    logic [3:0]         err;
    logic               hard_err;
    logic               accept;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [DATA_W-1:0]  div_q;

    assign accept    = cmd_valid && cmd_ready && (state == ST_IDLE);
    assign idx_b     = (depth >= ONE) ? depth - ONE : '0;
    assign idx_a     = (depth >= TWO) ? depth - TWO : '0;
    assign opb       = stack[idx_b];
    assign opa       = stack[idx_a];
    assign hard_err  = |err[2:0];
    assign div_start = accept && !hard_err && (cmd_op == OP_DIV);

    // Full-precision ALU, reduced to DATA_W by wrapping or clamping.
    always_comb begin
        sum  = {1'b0, opa} - {1'b0, opb} + {1'b0, opb} + {1'b0, opb};
        diff = {1'b0, opa} - {1'b0, opb};
        prod = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};
        case (cmd_op)
            OP_ADD: begin
                aovf    = sum[DATA_W];
                alu_res = (aovf && SATURATE != 0) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
            end
            OP_SUB: begin
                aovf    = diff[DATA_W];
                alu_res = (aovf && SATURATE != 0) ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
            end
            OP_MUL: begin
                aovf    = |prod[2*DATA_W-1:DATA_W];
                alu_res = (aovf && SATURATE != 0) ? {DATA_W{1'b1}} : prod[DATA_W-1:0];
            end
            default: begin
                aovf    = 1'b0;
                alu_res = {DATA_W{1'b0}};
            end
        endcase
    end

    // Precondition checks; arith_ovf is only a warning and never blocks the write.
    always_comb begin
        err = 4'b0000;
        case (cmd_op)
            OP_PUSH: err[ERR_SOVF] = (depth == FULL);
            OP_DROP: err[ERR_UNF]  = (depth == '0);
            OP_DUP: begin
                err[ERR_UNF]  = (depth == '0);
                err[ERR_SOVF] = (depth == FULL);
            end
            OP_DIV: begin
                err[ERR_UNF]  = (depth < TWO);
                err[ERR_DIV0] = (depth >= TWO) && (opb == {DATA_W{1'b0}});
            end
            OP_ADD, OP_SUB, OP_MUL: begin
                err[ERR_UNF]  = (depth < TWO);
                err[ERR_AOVF] = (depth >= TWO) && aovf;
            end
            OP_SWAP: err[ERR_UNF] = (depth < TWO);
            default: err = 4'b0000;
        endcase
    end

    rpn_divider #(.DATA_W(DATA_W)) u_div (
        .clk   (CLOCK_50),
        .rst   (reset),
        .start (div_start),
        .a     (opa),
        .b     (opb),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    // Command FSM, stack update and registered response/status outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 4'b0000;
            top       <= '0;
            depth     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 4'b0000;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (hard_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                        end else if (cmd_op == OP_DIV) begin
                            state     <= ST_DIV_RUN;
                            cmd_ready <= 1'b0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                            case (cmd_op)
                                OP_PUSH: begin
                                    stack[depth] <= cmd_data;
                                    depth        <= depth + ONE;
                                    top          <= cmd_data;
                                end
                                OP_DROP: begin
                                    depth <= depth - ONE;
                                    top   <= (depth >= TWO) ? opa : {DATA_W{1'b0}};
                                end
                                OP_DUP: begin
                                    stack[depth] <= opb;
                                    depth        <= depth + ONE;
                                    top          <= opb;
                                end
                                OP_SWAP: begin
                                    stack[idx_a] <= opb;
                                    stack[idx_b] <= opa;
                                    top          <= opa;
                                end
                                default: begin
                                    stack[idx_a] <= alu_res;
                                    depth        <= depth - ONE;
                                    top          <= alu_res;
                                end
                            endcase
                        end
                    end
                end
                ST_DIV_RUN: begin
                    if (div_done) begin
                        stack[idx_a] <= div_q;
                        depth        <= depth - ONE;
                        top          <= div_q;
                        rsp_valid    <= 1'b1;
                        cmd_ready    <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (!div_busy) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_core.sv
// Bench for rpn_stack_core: a wrapping and a saturating instance share the command
// port and are compared against an array-based reference model of the calculator.
module tb_rpn_stack_core;
    localparam int W = 8;
    localparam int D = 4;

    logic            CLOCK_50 = 1'b0;
    logic            reset    = 1'b1;
    logic            cmd_valid = 1'b0;
    logic [2:0]      cmd_op    = 3'd0;
    logic [W-1:0]    cmd_data  = '0;
    logic [1:0]      rdy;
    logic [1:0]      rv;
    logic [3:0]      rerr [2];
    logic [W-1:0]    tp   [2];
    logic [2:0]      dp   [2];

    int checks = 0;
    int errors = 0;
    int m_stk [2][D];
    int m_cnt [2];

    always #5 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rpn_stack_core #(.DATA_W(W), .DEPTH(D), .SATURATE(g)) dut (
            .CLOCK_50  (CLOCK_50),
            .reset     (reset),
            .cmd_valid (cmd_valid),
            .cmd_ready (rdy[g]),
            .cmd_op    (cmd_op),
            .cmd_data  (cmd_data),
            .rsp_valid (rv[g]),
            .rsp_err   (rerr[g]),
            .top       (tp[g]),
            .depth     (dp[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference calculator: plain integer arithmetic on an array stack.
    function automatic void model_step(input int s, input int op, input int d,
                                       output int err, output int lat);
        int a, b, r, n;
        bit sat;
        n   = m_cnt[s];
        sat = (s == 1);
        err = 0;
        lat = 1;
        r   = 0;
        b   = (n >= 1) ? m_stk[s][n-1] : 0;
        a   = (n >= 2) ? m_stk[s][n-2] : 0;
        case (op)
            0: if (n == D) err = 2; else begin m_stk[s][n] = d; m_cnt[s] = n + 1; end
            1: if (n == 0) err = 1; else m_cnt[s] = n - 1;
            6: if (n < 2) err = 1; else begin m_stk[s][n-2] = b; m_stk[s][n-1] = a; end
            7: if (n == 0) err = 1; else if (n == D) err = 2;
               else begin m_stk[s][n] = b; m_cnt[s] = n + 1; end
            default: begin
                if (n < 2) err = 1;
                else if (op == 5 && b == 0) err = 4;
                else begin
                    case (op)
                        2: r = a + b;
                        3: r = a - b;
                        4: r = a * b;
                        default: begin r = a / b; lat = W + 1; end
                    endcase
                    if (r > 255) begin err = 8; r = sat ? 255 : r % 256; end
                    else if (r < 0) begin err = 8; r = sat ? 0 : r + 256; end
                    m_stk[s][n-2] = r;
                    m_cnt[s] = n - 1;
                end
            end
        endcase
    endfunction

    function automatic int model_top(input int s);
        return (m_cnt[s] == 0) ? 0 : m_stk[s][m_cnt[s]-1];
    endfunction

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_depth%0d", s), 32'(dp[s]), 32'd0);
            check($sformatf("rst_top%0d", s), 32'(tp[s]), 32'd0);
            check($sformatf("rst_ready%0d", s), 32'(rdy[s]), 32'd1);
            check($sformatf("rst_rv%0d", s), 32'(rv[s]), 32'd0);
            check($sformatf("rst_err%0d", s), 32'(rerr[s]), 32'd0);
            m_cnt[s] = 0;
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic do_cmd(input int op, input int d);
        int e [2];
        int l [2];
        int got [2];
        int lo [2];
        int ge [2];
        int gt [2];
        int gd [2];
        int wn;
        for (int s = 0; s < 2; s++) begin
            model_step(s, op, d, e[s], l[s]);
            got[s] = 0; lo[s] = 0; ge[s] = -1; gt[s] = -1; gd[s] = -1;
        end
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_data  = d[W-1:0];
        wn = 0;
        while (rdy != 2'b11 && wn < 40) begin
            @(negedge CLOCK_50);
            wn++;
        end
        check($sformatf("ready_wait_op%0d", op), 32'(wn < 40), 32'd1);
        @(posedge CLOCK_50);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLOCK_50);
            if (k == 1) cmd_valid = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (got[s] == 0) begin
                    if (!rdy[s]) lo[s]++;
                    if (rv[s]) begin
                        got[s] = k; ge[s] = int'(rerr[s]); gt[s] = int'(tp[s]); gd[s] = int'(dp[s]);
                    end
                end
            end
            if (got[0] != 0 && got[1] != 0) break;
        end
        for (int s = 0; s < 2; s++) begin
            check($sformatf("lat%0d_op%0d", s, op), 32'(got[s]), 32'(l[s]));
            check($sformatf("err%0d_op%0d", s, op), 32'(ge[s]), 32'(e[s]));
            check($sformatf("top%0d_op%0d", s, op), 32'(gt[s]), 32'(model_top(s)));
            check($sformatf("depth%0d_op%0d", s, op), 32'(gd[s]), 32'(m_cnt[s]));
            check($sformatf("stall%0d_op%0d", s, op), 32'(lo[s]), 32'(l[s] - 1));
        end
        @(negedge CLOCK_50);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rv_idle%0d", s), 32'(rv[s]), 32'd0);
            check($sformatf("err_idle%0d", s), 32'(rerr[s]), 32'd0);
        end
    endtask

    initial begin
        int op, d;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        do_reset();

        // Add overflow: wrap vs clamp.
        do_cmd(0, 'hAE); do_cmd(0, 'h83); do_cmd(2, 0);
        check("t1_top_wrap", 32'(tp[0]), 32'h31);
        check("t1_top_sat", 32'(tp[1]), 32'hFF);

        // Stack overflow, SWAP and DUP at full depth.
        do_reset();
        for (int i = 1; i <= 5; i++) do_cmd(0, i);
        check("t2_depth_full", 32'(dp[0]), 32'd4);
        do_cmd(6, 0);
        check("t2_swap_top", 32'(tp[0]), 32'h03);
        do_cmd(7, 0);

        // Underflow cases from an empty stack.
        do_reset();
        do_cmd(2, 0); do_cmd(1, 0); do_cmd(0, 9); do_cmd(6, 0);
        check("t3_top", 32'(tp[0]), 32'h09);

        // Divide latency and divide by zero.
        do_reset();
        do_cmd(0, 'hC8); do_cmd(0, 'h07); do_cmd(5, 0);
        check("t4_quot", 32'(tp[0]), 32'h1C);
        do_cmd(0, 0); do_cmd(5, 0);

        // Subtract borrow and multiply overflow.
        do_reset();
        do_cmd(0, 3); do_cmd(0, 5); do_cmd(3, 0);
        check("t5_sub_wrap", 32'(tp[0]), 32'hFE);
        check("t5_sub_sat", 32'(tp[1]), 32'h00);
        do_cmd(0, 'h10); do_cmd(7, 0); do_cmd(4, 0);

        // Reset in the middle of a divide.
        do_reset();
        do_cmd(0, 'hC8); do_cmd(0, 'h07);
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        check("t6_busy", 32'(rdy), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check("t6_depth", 32'(dp[0]), 32'd0);
        check("t6_top", 32'(tp[0]), 32'd0);
        check("t6_ready", 32'(rdy), 32'd3);
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLOCK_50);
            check("t6_no_rsp", 32'(rv), 32'd0);
        end

        // Random command stream against the model.
        for (int i = 0; i < 300; i++) begin
            if (i % 75 == 74) do_reset();
            op = $urandom_range(0, 7);
            if (m_cnt[0] < 2 && $urandom_range(0, 1) == 1) op = 0;
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            do_cmd(op, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
